instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port reset  in  1  asynchronous, active-high reset.
REQ-004 Port imemAddr  out  32  instruction-memory byte address.
REQ-005 Port imemReq  out  1  memory request, held until acknowledged.
REQ-006 Port imemAck  in  1  memory response strobe; imemData valid this cycle.
REQ-007 Port imemData  in  32  instruction word returned by memory.
REQ-008 Port instruction  out  32  fetched word presented to the decoder (Processor).
REQ-009 Port instructionValid  out  1  instruction/pc valid for consumption.
REQ-010 Port pc  out  32  byte address of the presented instruction.
REQ-011 Port instrAccept  in  1  decoder consumes the instruction when high with instructionValid.
REQ-012 Port branchResolve  in  1  one-cycle strobe; branch inputs valid this cycle.
REQ-013 Port branchFlag  in  1  conditional branch (CBZ) indicator.
REQ-014 Port unconditionalBranchFlag  in  1  unconditional branch (B) indicator.
REQ-015 Port zeroFlag  in  1  ALU zero result for the resolving branch.
REQ-016 Port branchPC  in  32  byte address of the resolving branch.
REQ-017 Port branchOffset  in  32  sign-extended word offset of the branch.
REQ-018 Port fetchCount  out  32  accepted-instruction counter (only with FETCH_PERF_CNT_EN).

Function
REQ-019 FSM states IDLE, REQ, HOLD; IDLE lasts exactly one cycle after reset release, then REQ.
REQ-020 In REQ, imemReq=1 and imemAddr=fetchPC, stable until the imemAck cycle.
REQ-021 On imemAck in REQ with no pending redirect: capture imemData into instruction, fetchPC into pc, go HOLD with instructionValid=1 next cycle (one-cycle latency after ack).
REQ-022 In HOLD, imemReq=0; instruction and pc held stable until accepted.
REQ-023 Accept (instrAccept & instructionValid): fetchPC <= pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), instructionValid=0, go REQ next cycle.
REQ-024 Branch taken = branchResolve & (unconditionalBranchFlag | (branchFlag & zeroFlag)); target = branchPC + (branchOffset << 2), 32-bit modular.
REQ-025 branchResolve with taken=0 has no effect.
REQ-026 Taken branch in HOLD: drop instructionValid next cycle, fetchPC <= target, go REQ.
REQ-027 Taken branch in REQ before ack: set pendingRedirect, fetchPC <= target; imemReq/imemAddr unchanged until ack; the acked word is discarded, then REQ re-issues at target.
REQ-028 Taken branch in the same cycle as imemAck: word discarded, next REQ at target.
REQ-029 Taken branch in IDLE: fetchPC <= target; first request goes to target.
REQ-030 Taken branch and accept in the same cycle: accept counted, next fetch address is target, not pc+4.
REQ-031 Second taken branch while pendingRedirect set: later target overwrites.
REQ-032 imemAck outside REQ is ignored.

Reset
REQ-033 Asserting reset at any time, including mid-request, forces IDLE, fetchPC=RESET_PC, pc=RESET_PC, instruction=0, instructionValid=0, imemReq=0, imemAddr=RESET_PC, pendingRedirect=0, fetchCount=0.
REQ-034 An imemAck for a request outstanding across reset is ignored.

Configuration
REQ-035 Macro FETCH_PERF_CNT_EN defined: fetchCount increments by 1 per accept, wraps at 2^32, reset to 0.
REQ-036 Macro FETCH_PERF_CNT_EN undefined: fetchCount port present, tied to 0, no counter register.

Verification
REQ-037 Reset release, imemAck after 2 wait cycles, imemData=32'h8B150289 -> imemAddr=0 during REQ; instruction=32'h8B150289, pc=0, valid one cycle after ack.
REQ-038 Three back-to-back accepts with immediate ack -> pc sequence 0, 4, 8; fetchCount=3 (macro on), 0 (macro off).
REQ-039 HOLD pc=8, branchResolve, unconditionalBranchFlag=1, branchPC=8, branchOffset=-2 -> valid drops; next imemAddr=0.
REQ-040 REQ outstanding at 12, CBZ resolve zeroFlag=1, branchPC=4, branchOffset=5 -> word at 12 discarded; next imemAddr=24; with zeroFlag=0, word at 12 presented.
REQ-041 RESET_PC=32'hFFFF_FFFC, accept -> next imemAddr=0.
REQ-042 Reset asserted while imemReq=1, late imemAck during reset -> all outputs at reset values, no instructionValid.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: IDLE/REQ/HOLD request FSM with branch redirect.
// Optional FETCH_PERF_CNT_EN macro adds an accepted-instruction counter on fetchCount.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imemAddr,
  output logic        imemReq,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] instruction,
  output logic        instructionValid,
  output logic [31:0] pc,
  input  logic        instrAccept,
  input  logic        branchResolve,
  input  logic        branchFlag,
  input  logic        unconditionalBranchFlag,
  input  logic        zeroFlag,
  input  logic [31:0] branchPC,
  input  logic [31:0] branchOffset,
  output logic [31:0] fetchCount,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;
  logic        pending_q, pending_d;

  logic        taken;
  logic [31:0] target;
  logic        accept;

  assign taken  = branchResolve & (unconditionalBranchFlag | (branchFlag & zeroFlag));
  assign target = branchPC + {branchOffset[29:0], 2'b00};
  assign accept = instrAccept & valid_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    pending_d  = pending_q;
    case (state_q)
      IDLE: begin
        if (taken) fetch_pc_d = target;
        state_d = REQ;
        addr_d  = fetch_pc_d;
      end
      REQ: begin
        if (imemAck) begin
          if (pending_q || taken) begin
            // Word belongs to a squashed path: drop it and re-issue at the redirect.
            if (taken) fetch_pc_d = target;
            pending_d = 1'b0;
            addr_d    = fetch_pc_d;
          end else begin
            instr_d = imemData;
            pc_d    = fetch_pc_q;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end else if (taken) begin
          pending_d  = 1'b1;
          fetch_pc_d = target;
        end
      end
      HOLD: begin
        if (taken || accept) begin
          fetch_pc_d = taken ? target : pc_q + 32'd4;
          valid_d    = 1'b0;
          state_d    = REQ;
          addr_d     = fetch_pc_d;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == REQ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
      pending_q  <= pending_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (state_q == HOLD && accept) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= 32'd0;
    else       count_q <= count_d;
  end

  assign fetchCount = count_q;
`else
  assign fetchCount = 32'd0;
`endif

  assign imemAddr         = addr_q;
  assign imemReq          = req_q;
  assign instruction      = instr_q;
  assign instructionValid = valid_q;
  assign pc               = pc_q;
  assign fsm_state        = state_q;

endmodule
